// File: rtl/point_encoder_pkg.sv
// -----------------------------------------------------------------------------
// point_encoder_pkg
// Shared constants and types for the Ed448 point encoder.
//   DATA_WIDTH  : field element width, p = 2^448 - 2^224 - 1
//   ENC_WIDTH   : encoded point width (57 bytes)
//   P_MOD       : field prime
//   P_MINUS_2   : Fermat inversion exponent
//   R_MOD_P     : Montgomery R = 2^448 mod p (Montgomery form of 1)
//   R2_MOD_P    : R^2 mod p (Montgomery form of R)
//   fe_t        : field element
//   fe_wide_t   : unreduced Montgomery product, always < 2p
//   enc_state_t : encoder FSM states
// -----------------------------------------------------------------------------
package point_encoder_pkg;

    localparam int unsigned DATA_WIDTH = 448;
    localparam int unsigned ENC_WIDTH  = 456;
    localparam int unsigned HALF_WIDTH = 224;
    localparam int unsigned BIT_W      = 9;

    typedef logic [DATA_WIDTH-1:0] fe_t;
    typedef logic [DATA_WIDTH:0]   fe_wide_t;

    localparam fe_t P_MOD     = ~fe_t'(0) - (fe_t'(1) << HALF_WIDTH);
    localparam fe_t P_MINUS_2 = P_MOD - fe_t'(2);
    localparam fe_t R_MOD_P   = (fe_t'(1) << HALF_WIDTH) | fe_t'(1);
    localparam fe_t R2_MOD_P  = (fe_t'(3) << HALF_WIDTH) | fe_t'(2);

    typedef enum logic [3:0] {
        StIdle,
        StInvInit,
        StInvSqr,
        StInvMul,
        StMulX,
        StMulY,
        StFromMontX,
        StFromMontY,
        StFinish
    } enc_state_t;

    // Product is < 2p, so one conditional subtraction gives a canonical value.
    function automatic fe_t reduce_once(input fe_wide_t v);
        fe_wide_t t;
        if (v >= {1'b0, P_MOD}) begin
            t = v - {1'b0, P_MOD};
        end else begin
            t = v;
        end
        return fe_t'(t);
    endfunction

endpackage

// File: rtl/mont_mul.sv
// -----------------------------------------------------------------------------
// mont_mul
// Montgomery multiplier for p = 2^448 - 2^224 - 1, R = 2^448.
// Returns a*b*R^-1 mod p, not fully reduced (result < 2p for a, b < p).
//   clk     : clock
//   rst     : asynchronous active-high reset, abandons any operation
//   i_start : one-cycle pulse, operands sampled on this edge
//   i_a/i_b : operands
//   o_done  : one-cycle pulse MUL_LAT cycles after the start cycle
//   o_res   : product, valid from o_done until the next start
// -----------------------------------------------------------------------------
module mont_mul
    import point_encoder_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_start,
    input  fe_t      i_a,
    input  fe_t      i_b,
    output logic     o_done,
    output fe_wide_t o_res
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH + 2;

    typedef logic [PROD_W-1:0]  prod_t;
    typedef logic [MUL_LAT-1:0] pipe_t;

    prod_t    w_t;
    prod_t    w_s1;
    prod_t    w_s2;
    pipe_t    r_pipe;
    fe_wide_t r_res;

    // p == -1 mod 2^224, so with a 2^224 digit -p^-1 is 1 and each reduction
    // round simply adds (low digit)*p and drops the low digit. Two rounds give R.
    always_comb begin
        w_t  = prod_t'(i_a) * prod_t'(i_b);
        w_s1 = (w_t + prod_t'(w_t[HALF_WIDTH-1:0]) * prod_t'(P_MOD)) >> HALF_WIDTH;
        w_s2 = (w_s1 + prod_t'(w_s1[HALF_WIDTH-1:0]) * prod_t'(P_MOD)) >> HALF_WIDTH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
            r_res  <= '0;
        end else begin
            r_pipe <= (r_pipe << 1) | pipe_t'(i_start);
            if (i_start) begin
                r_res <= fe_wide_t'(w_s2);
            end
        end
    end

    assign o_done = r_pipe[MUL_LAT-1];
    assign o_res  = r_res;

endmodule

// File: rtl/point_encoder.sv
// -----------------------------------------------------------------------------
// point_encoder
// Converts a projective Ed448 point (X:Y:Z, Montgomery domain) to affine
// (x, y) in the normal domain and forms the 57-byte point encoding.
// Z^-1 is computed as Z^(p-2) with one shared Montgomery multiplier; the
// sequence of operations is fixed by the exponent, never by the data.
//   clk     : clock
//   rst     : asynchronous active-high reset
//   start   : one-cycle pulse, X/Y/Z sampled when idle
//   X, Y, Z : projective coordinates, Montgomery domain
//   busy    : computation in progress
//   done    : one-cycle pulse, results valid
//   x_out   : affine x, canonical
//   y_out   : affine y, canonical
//   enc_out : {x_out[0], 7'b0, y_out}
//   err     : Z was zero, valid with done
// -----------------------------------------------------------------------------
module point_encoder
    import point_encoder_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] X,
    input  logic [DATA_WIDTH-1:0] Y,
    input  logic [DATA_WIDTH-1:0] Z,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] x_out,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic [ENC_WIDTH-1:0]  enc_out,
    output logic                  err
);

    enc_state_t r_state;
    enc_state_t w_state_d;

    fe_t r_x_in;
    fe_t r_y_in;
    fe_t r_z_in;
    fe_t r_acc;
    fe_t r_tx;
    fe_t r_ty;
    fe_t r_x_out;
    fe_t r_y_out;

    logic [ENC_WIDTH-1:0] r_enc;
    logic                 r_done;
    logic                 r_err;
    logic                 r_wait;
    logic                 w_wait_d;
    logic [BIT_W-1:0]     r_bit;
    logic [BIT_W-1:0]     w_bit_d;

    logic     w_load;
    logic     w_acc_init;
    logic     w_is_mul;
    logic     w_step;
    logic     w_mm_start;
    logic     w_mm_done;
    fe_t      w_mm_a;
    fe_t      w_mm_b;
    fe_wide_t w_mm_res;
    fe_t      w_red;

    mont_mul #(
        .MUL_LAT (MUL_LAT)
    ) u_mont_mul (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_mm_start),
        .i_a     (w_mm_a),
        .i_b     (w_mm_b),
        .o_done  (w_mm_done),
        .o_res   (w_mm_res)
    );

    assign w_red    = reduce_once(w_mm_res);
    assign w_is_mul = r_state inside {StInvSqr, StInvMul, StMulX, StMulY,
                                      StFromMontX, StFromMontY};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_wait_d   = r_wait;
        w_bit_d    = r_bit;
        w_load     = 1'b0;
        w_acc_init = 1'b0;
        w_mm_start = 1'b0;
        w_mm_a     = r_acc;
        w_mm_b     = r_acc;

        // Every multiply state: issue one start, then hold until done.
        w_step = w_is_mul && r_wait && w_mm_done;
        if (w_is_mul) begin
            if (!r_wait) begin
                w_mm_start = 1'b1;
                w_wait_d   = 1'b1;
            end else if (w_mm_done) begin
                w_wait_d = 1'b0;
            end
        end

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_d = StInvInit;
                end
            end
            StInvInit: begin
                // acc = Z accounts for the exponent MSB (bit 447).
                w_acc_init = 1'b1;
                w_bit_d    = BIT_W'(DATA_WIDTH - 2);
                w_state_d  = StInvSqr;
            end
            StInvSqr: begin
                if (w_step) begin
                    if (P_MINUS_2[r_bit]) begin
                        w_state_d = StInvMul;
                    end else if (r_bit == '0) begin
                        w_state_d = StMulX;
                    end else begin
                        w_bit_d = r_bit - BIT_W'(1);
                    end
                end
            end
            StInvMul: begin
                w_mm_b = r_z_in;
                if (w_step) begin
                    if (r_bit == '0) begin
                        w_state_d = StMulX;
                    end else begin
                        w_bit_d   = r_bit - BIT_W'(1);
                        w_state_d = StInvSqr;
                    end
                end
            end
            StMulX: begin
                w_mm_a = r_x_in;
                if (w_step) w_state_d = StMulY;
            end
            StMulY: begin
                w_mm_a = r_y_in;
                if (w_step) w_state_d = StFromMontX;
            end
            StFromMontX: begin
                w_mm_a = r_tx;
                w_mm_b = fe_t'(1);
                if (w_step) w_state_d = StFromMontY;
            end
            StFromMontY: begin
                w_mm_a = r_ty;
                w_mm_b = fe_t'(1);
                if (w_step) w_state_d = StFinish;
            end
            StFinish: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait  <= 1'b0;
            r_bit   <= '0;
            r_x_in  <= '0;
            r_y_in  <= '0;
            r_z_in  <= '0;
            r_acc   <= '0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_enc   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_wait <= w_wait_d;
            r_bit  <= w_bit_d;
            r_done <= (r_state == StFinish);
            if (w_load) begin
                r_x_in <= X;
                r_y_in <= Y;
                r_z_in <= Z;
            end
            if (w_acc_init) begin
                r_acc <= r_z_in;
            end
            // tx/ty are overwritten in place by their normal-domain values.
            if (w_step) begin
                case (r_state)
                    StInvSqr, StInvMul:  r_acc <= w_red;
                    StMulX, StFromMontX: r_tx  <= w_red;
                    StMulY, StFromMontY: r_ty  <= w_red;
                    default: ;
                endcase
            end
            if (r_state == StFinish) begin
                r_x_out <= r_tx;
                r_y_out <= r_ty;
                r_enc   <= {r_tx[0], 7'b0, r_ty};
                r_err   <= (r_z_in == '0);
            end
        end
    end

    assign busy    = (r_state != StIdle);
    assign done    = r_done;
    assign x_out   = r_x_out;
    assign y_out   = r_y_out;
    assign enc_out = r_enc;
    assign err     = r_err;

endmodule

// File: tb/tb_point_encoder.sv
// -----------------------------------------------------------------------------
// tb_point_encoder
// Scoreboard bench for point_encoder: expected results are queued when a
// start is driven and compared when done pulses.
// -----------------------------------------------------------------------------
module tb_point_encoder;

    localparam int unsigned DW      = 448;
    localparam int unsigned EW      = 456;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned LAT_EXP = 896 * (MUL_LAT + 1) + 3;
    localparam int unsigned LIMIT   = LAT_EXP + 64;

    typedef logic [DW-1:0] fe_t;
    typedef logic [EW-1:0] enc_t;
    typedef struct packed {
        fe_t  x;
        fe_t  y;
        enc_t enc;
        logic err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    fe_t  X     = '0;
    fe_t  Y     = '0;
    fe_t  Z     = '0;
    logic busy;
    logic done;
    fe_t  x_out;
    fe_t  y_out;
    enc_t enc_out;
    logic err;

    exp_t sb[$];
    exp_t last_exp = '0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    int   dc0      = 0;
    fe_t  one_m;
    fe_t  r2_m;

    point_encoder #(
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .X       (X),
        .Y       (Y),
        .Z       (Z),
        .busy    (busy),
        .done    (done),
        .x_out   (x_out),
        .y_out   (y_out),
        .enc_out (enc_out),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input enc_t obs, input enc_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input fe_t x, input fe_t y, input logic e);
        exp_t r;
        r.x   = x;
        r.y   = y;
        r.enc = {x[0], 7'b0, y};
        r.err = e;
        return r;
    endfunction

    // Called at a negedge; start is sampled by the following posedge.
    task automatic do_start(input fe_t xi, input fe_t yi, input fe_t zi);
        X     = xi;
        Y     = yi;
        Z     = zi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Latency counts rising edges, the edge that samples start being number 1.
    task automatic wait_done(input int c0, output int cyc, output bit seen);
        cyc  = c0;
        seen = 1'b0;
        while (cyc < int'(LIMIT)) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic collect(input string tag, input int c0);
        int   cyc;
        bit   seen;
        exp_t e;
        wait_done(c0, cyc, seen);
        check({tag, " done_seen"}, enc_t'(seen), enc_t'(1));
        e = '0;
        if (sb.size() != 0) e = sb.pop_front();
        if (seen) begin
            check({tag, " latency"}, enc_t'(cyc), enc_t'(LAT_EXP));
            check({tag, " x_out"}, enc_t'(x_out), enc_t'(e.x));
            check({tag, " y_out"}, enc_t'(y_out), enc_t'(e.y));
            check({tag, " enc_out"}, enc_out, e.enc);
            check({tag, " err"}, enc_t'(err), enc_t'(e.err));
            check({tag, " busy_at_done"}, enc_t'(busy), enc_t'(0));
            @(negedge clk);
            #1;
            check({tag, " done_pulse"}, enc_t'(done), enc_t'(0));
            check({tag, " done_count"}, enc_t'(done_cnt - dc0), enc_t'(1));
            last_exp = e;
        end
    endtask

    task automatic run_case(input string tag, input fe_t xi, input fe_t yi, input fe_t zi,
                            input exp_t e);
        sb.push_back(e);
        dc0 = done_cnt;
        do_start(xi, yi, zi);
        check({tag, " busy"}, enc_t'(busy), enc_t'(1));
        check({tag, " hold_x"}, enc_t'(x_out), enc_t'(last_exp.x));
        check({tag, " hold_enc"}, enc_out, last_exp.enc);
        collect(tag, 1);
    endtask

    initial begin
        int dc;
        one_m = (fe_t'(1) << 224) | fe_t'(1);
        r2_m  = (fe_t'(3) << 224) | fe_t'(2);

        repeat (3) @(negedge clk);
        check("reset busy", enc_t'(busy), enc_t'(0));
        check("reset done", enc_t'(done), enc_t'(0));
        check("reset err", enc_t'(err), enc_t'(0));
        check("reset x_out", enc_t'(x_out), enc_t'(0));
        check("reset enc_out", enc_out, enc_t'(0));
        rst = 1'b0;
        @(negedge clk);

        run_case("affine11", one_m, one_m, one_m, mk_exp(fe_t'(1), fe_t'(1), 1'b0));
        run_case("neutral", fe_t'(0), one_m, one_m, mk_exp(fe_t'(0), fe_t'(1), 1'b0));
        run_case("scaled_r", r2_m, r2_m, r2_m, mk_exp(fe_t'(1), fe_t'(1), 1'b0));
        run_case("z_zero", one_m, one_m, fe_t'(0), mk_exp(fe_t'(0), fe_t'(0), 1'b1));
        run_case("x_r", r2_m, r2_m, one_m, mk_exp(one_m, one_m, 1'b0));

        // Second start at edge 100 must be ignored.
        sb.push_back(mk_exp(fe_t'(1), fe_t'(1), 1'b0));
        dc0 = done_cnt;
        do_start(one_m, one_m, one_m);
        repeat (98) @(negedge clk);
        do_start(fe_t'(0), r2_m, r2_m);
        collect("chain", 100);

        // Reset in the middle of a run.
        do_start(r2_m, r2_m, one_m);
        repeat (499) @(negedge clk);
        check("rst busy_before", enc_t'(busy), enc_t'(1));
        rst = 1'b1;
        #1;
        check("rst busy", enc_t'(busy), enc_t'(0));
        check("rst done", enc_t'(done), enc_t'(0));
        check("rst err", enc_t'(err), enc_t'(0));
        check("rst x_out", enc_t'(x_out), enc_t'(0));
        check("rst y_out", enc_t'(y_out), enc_t'(0));
        check("rst enc_out", enc_out, enc_t'(0));
        dc = done_cnt;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (LIMIT) @(negedge clk);
        check("rst no_done", enc_t'(done_cnt), enc_t'(dc));
        check("rst idle", enc_t'(busy), enc_t'(0));
        last_exp = '0;

        run_case("fresh", r2_m, r2_m, one_m, mk_exp(one_m, one_m, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/point_encoder.md
Name: point_encoder

Overview:
- Downstream stage of the Montgomery ladder.
- Takes the projective Ed448 result (X:Y:Z), held in Montgomery domain, and converts it to affine (x, y) = (X/Z, Y/Z) in the normal domain.
- Produces the 57-byte RFC 8032 point encoding.
- Inversion is Fermat: Z^(p-2), computed with a single shared mont_mul instance. The block feeds the signature R/A encoding path.

Parameters:
- DATA_WIDTH, 448: field element width, p = 2^448 - 2^224 - 1.
- ENC_WIDTH, 456: encoded point width (57 bytes).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; X/Y/Z sampled on the same edge.
- X  in  DATA_WIDTH  projective X, Montgomery domain.
- Y  in  DATA_WIDTH  projective Y, Montgomery domain.
- Z  in  DATA_WIDTH  projective Z, Montgomery domain.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are valid.
- x_out  out  DATA_WIDTH  affine x, normal domain, fully reduced (< p).
- y_out  out  DATA_WIDTH  affine y, normal domain, fully reduced.
- enc_out  out  ENC_WIDTH  {x_out[0], 7'b0, y_out}; byte 0 = LSB of y.
- err  out  1  Z was zero; valid with done.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; busy=0, done=0, err=0.
  - x_out, y_out, enc_out are all 0; internal accumulators are cleared.
  - A mont_mul operation in flight is abandoned, and its done is ignored after reset.
- start handling:
  - start in IDLE latches X, Y, Z into internal registers.
  - start while busy=1 is ignored and does not disturb the running operation.
- FSM states: IDLE -> INV_INIT -> INV_SQR <-> INV_MUL -> MUL_X -> MUL_Y -> FROM_MONT_X -> FROM_MONT_Y -> FINISH -> IDLE.
- Inversion:
  - Left-to-right square-and-multiply over E = p-2 (constant P_MINUS_2), MSB at bit 447.
  - acc = Z at INV_INIT, covering bit 447.
  - For bits 446..0: INV_SQR acc=acc*acc; if E[bit]=1 then INV_MUL acc=acc*Z.
  - Totals: 447 squarings and 445 multiplies, because E has a popcount of 446.
  - Bit index is a 9-bit down-counter; leave the loop after bit 0 is processed.
- After the inversion loop:
  - MUL_X: tx = X*acc. MUL_Y: ty = Y*acc.
  - FROM_MONT_X: x = tx*1. FROM_MONT_Y: y = ty*1. Each is a Montgomery multiply by literal 1, which leaves the Montgomery domain.
- mont_mul usage:
  - Each multiply uses its start/done handshake: one start pulse, then wait for done.
  - Operands are held stable while waiting.
  - Total multiply count is 896.
  - Latency = 896*(MUL_LAT+1) + 3 cycles from start to done, where MUL_LAT is the mont_mul latency.
- Reduction: if a mont_mul result is >= p, subtract p once before storing, so outputs are canonical.
- FINISH (single cycle):
  - Register x_out, y_out, enc_out, and err = (Z_latched == 0).
  - Pulse done for one cycle; busy drops in the same cycle.
  - Outputs hold until the next accepted start; they do not change during the next computation until its FINISH.
- Z = 0: the inversion yields 0, so x_out = y_out = 0, enc_out = 0, err = 1. Same latency as the normal case; no early exit, so timing is constant.
- Constant time: the FSM path depends only on E, never on the data. Required for side-channel hygiene.

Decomposition:
- Additions to parameters_pkg:
  - P_MOD, P_MINUS_2, R_MOD_P, R2_MOD_P, ENC_WIDTH.
  - typedef fe_t (logic [DATA_WIDTH-1:0]).
  - enum enc_state_t for the FSM.
- Sub-module: reuse the existing mont_mul (single instance). No new sub-module.

Test Plan:
- X=Y=Z=R_MOD_P (affine (1,1)) -> x_out=1, y_out=1, enc_out=(1<<455)|1, err=0; done exactly once, at 896*(MUL_LAT+1)+3 cycles.
- X=0, Y=Z=R_MOD_P (neutral point) -> x_out=0, y_out=1, enc_out=1, err=0.
- X=Y=Z=R2_MOD_P (the same point (1:1:1) scaled by R) -> identical outputs to the first test. Proves Z-scaling invariance.
- Z=0, X=Y=R_MOD_P -> err=1, x_out=y_out=enc_out=0, same latency as the first test.
- Chaining with mont_ladder: start, then pulse start again at cycle 100 with different X/Y/Z -> second start ignored, result matches the first inputs. Then assert rst at cycle 500 of a new run -> busy=0, outputs 0 immediately, no done. A fresh start afterwards completes correctly.
